serial_slave_port: RTL

- Parametrised next-generation slave endpoint for the team's 1-bit serial bus; decodes the master's serial control frame and services single or burst reads and writes against a local memory.
- Generalises the fixed UART slave: data width, address width and slave ID are parameters.
- Adds paced read-back, address wrap-around and an inactivity timeout with error reporting.
- Sits between the bus interconnect (control/wD/valid/last from the master, rD/ready back to it) and a private single-port RAM.

---
 rtl/serial_bus_pkg.sv | 32 +++
 rtl/slave_bram.sv | 29 ++
 rtl/serial_slave_port.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_bus_pkg.sv
// Shared types and frame constants for the 1-bit serial bus slave.
package serial_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CTRL,
    ST_DECODE,
    ST_WR_DATA,
    ST_RD_FETCH,
    ST_RD_SEND,
    ST_DONE
  } state_e;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } rdwr_e;

  typedef enum logic {
    SINGLE = 1'b0,
    BURST  = 1'b1
  } burst_e;

  localparam int unsigned START_WIDTH   = 3;
  localparam logic [2:0]  START_PATTERN = 3'b111;

  // Start bits + ID + rdWr + burst + address.
  function automatic int unsigned frame_len(input int unsigned id_w, input int unsigned addr_w);
    return START_WIDTH + id_w + 2 + addr_w;
  endfunction

endpackage

// File: rtl/slave_bram.sv
// Single-port synchronous RAM, write-first, one-cycle read latency.
module slave_bram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
      r_rdata       <= i_wdata;
    end else begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/serial_slave_port.sv
// Serial bus slave endpoint: decodes the master's control frame and services
// single/burst reads and writes against a private RAM, with idle timeout.
module serial_slave_port
  import serial_bus_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter int unsigned SLAVEID_WIDTH = 2,
  parameter int unsigned SLAVEID       = 1,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic clk,
  input  logic rstN,
  input  logic control,
  input  logic wD,
  input  logic valid,
  input  logic last,
  output logic rD,
  output logic ready,
  output logic busy,
  output logic err
);

  localparam int unsigned FRAME_LEN = frame_len(SLAVEID_WIDTH, ADDR_WIDTH);
  localparam int unsigned FW        = SLAVEID_WIDTH + 2 + ADDR_WIDTH;
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN);
  localparam int unsigned BIT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned TMO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic [FW-1:0]           r_frame, w_frame_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0]   r_shift, w_shift_nxt;
  logic [BIT_W-1:0]        r_bit, w_bit_nxt;
  logic [TMO_W-1:0]        r_tmo, w_tmo_nxt;
  logic                    r_phase, w_phase_nxt;
  logic                    r_last_seen, w_last_seen_nxt;
  logic                    r_we, w_we_nxt;
  logic [ADDR_WIDTH-1:0]   r_waddr, w_waddr_nxt;
  logic [DATA_WIDTH-1:0]   r_wdata, w_wdata_nxt;
  logic                    r_rd, w_rd_nxt;
  logic                    r_ready, w_ready_nxt;
  logic                    r_busy, w_busy_nxt;
  logic                    r_err, w_err_nxt;

  logic [SLAVEID_WIDTH-1:0] w_id;
  rdwr_e                    w_rdwr;
  burst_e                   w_burst;
  logic [ADDR_WIDTH-1:0]    w_faddr;
  logic                     w_start_exp;
  logic                     w_tmo_expired;
  logic                     w_word_end;
  logic [DATA_WIDTH-1:0]    w_shift_in;
  logic [DATA_WIDTH-1:0]    w_rdata;
  logic [ADDR_WIDTH-1:0]    w_ram_addr;

  // Frame fields stay stable for the whole transaction: r_frame only shifts in CTRL.
  assign w_id          = r_frame[ADDR_WIDTH+2 +: SLAVEID_WIDTH];
  assign w_rdwr        = rdwr_e'(r_frame[ADDR_WIDTH+1]);
  assign w_burst       = burst_e'(r_frame[ADDR_WIDTH]);
  assign w_faddr       = r_frame[ADDR_WIDTH-1:0];
  assign w_start_exp   = (r_cnt == '0) ? START_PATTERN[1] : START_PATTERN[0];
  assign w_tmo_expired = (r_tmo == TMO_W'(TIMEOUT - 1));
  assign w_word_end    = (r_bit == BIT_W'(DATA_WIDTH - 1));
  assign w_shift_in    = (r_shift << 1) | DATA_WIDTH'(wD);
  assign w_ram_addr    = r_we ? r_waddr : r_addr;

  slave_bram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bram (
    .clk     (clk),
    .i_we    (r_we),
    .i_addr  (w_ram_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_frame     <= '0;
      r_addr      <= '0;
      r_shift     <= '0;
      r_bit       <= '0;
      r_tmo       <= '0;
      r_phase     <= 1'b0;
      r_last_seen <= 1'b0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_rd        <= 1'b0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_frame     <= w_frame_nxt;
      r_addr      <= w_addr_nxt;
      r_shift     <= w_shift_nxt;
      r_bit       <= w_bit_nxt;
      r_tmo       <= w_tmo_nxt;
      r_phase     <= w_phase_nxt;
      r_last_seen <= w_last_seen_nxt;
      r_we        <= w_we_nxt;
      r_waddr     <= w_waddr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_rd        <= w_rd_nxt;
      r_ready     <= w_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // Next-state logic; outputs are derived from the next state so they register in step with it.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_frame_nxt     = r_frame;
    w_addr_nxt      = r_addr;
    w_shift_nxt     = r_shift;
    w_bit_nxt       = r_bit;
    w_tmo_nxt       = '0;
    w_phase_nxt     = 1'b0;
    w_last_seen_nxt = r_last_seen;
    w_we_nxt        = 1'b0;
    w_waddr_nxt     = r_waddr;
    w_wdata_nxt     = r_wdata;
    w_err_nxt       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (control == START_PATTERN[2]) begin
          w_state_nxt = ST_CTRL;
          w_cnt_nxt   = '0;
        end
      end

      ST_CTRL: begin
        w_frame_nxt = {r_frame[FW-2:0], control};
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        if (r_cnt < CNT_W'(START_WIDTH - 1) && control != w_start_exp) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_W'(FRAME_LEN - 2)) begin
          w_state_nxt = ST_DECODE;
        end
      end

      ST_DECODE: begin
        w_addr_nxt      = w_faddr;
        w_bit_nxt       = '0;
        w_last_seen_nxt = 1'b0;
        if (w_id != SLAVEID_WIDTH'(SLAVEID)) begin
          w_state_nxt = ST_IDLE;
        end else if (w_rdwr == WRITE) begin
          w_state_nxt = ST_WR_DATA;
        end else begin
          w_state_nxt = ST_RD_FETCH;
        end
      end

      ST_WR_DATA: begin
        if (valid) begin
          w_shift_nxt = w_shift_in;
          if (w_word_end) begin
            w_bit_nxt   = '0;
            w_we_nxt    = 1'b1;
            w_waddr_nxt = r_addr;
            w_wdata_nxt = w_shift_in;
            w_addr_nxt  = r_addr + ADDR_WIDTH'(1);
            if (w_burst == SINGLE || last) w_state_nxt = ST_DONE;
          end else begin
            w_bit_nxt = r_bit + BIT_W'(1);
          end
        end else if (w_tmo_expired) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = 1'b1;
        end else begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
      end

      // Phase 0 presents the address, phase 1 captures the RAM output.
      ST_RD_FETCH: begin
        if (!r_phase) begin
          w_phase_nxt = 1'b1;
        end else begin
          w_shift_nxt     = w_rdata;
          w_bit_nxt       = '0;
          w_last_seen_nxt = 1'b0;
          w_state_nxt     = ST_RD_SEND;
        end
      end

      ST_RD_SEND: begin
        if (valid) begin
          w_last_seen_nxt = r_last_seen | last;
          if (w_word_end) begin
            if (w_burst == SINGLE || r_last_seen || last) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_addr_nxt  = r_addr + ADDR_WIDTH'(1);
              w_state_nxt = ST_RD_FETCH;
            end
          end else begin
            w_bit_nxt   = r_bit + BIT_W'(1);
            w_shift_nxt = r_shift << 1;
          end
        end else if (w_tmo_expired) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = 1'b1;
        end else begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
      end

      ST_DONE: w_state_nxt = ST_IDLE;

      default: w_state_nxt = ST_IDLE;
    endcase

    w_rd_nxt    = (w_state_nxt == ST_RD_SEND) && w_shift_nxt[DATA_WIDTH-1];
    w_ready_nxt = (w_state_nxt != ST_RD_FETCH);
    w_busy_nxt  = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
  end

  assign rD    = r_rd;
  assign ready = r_ready;
  assign busy  = r_busy;
  assign err   = r_err;

endmodule
